// File: rtl/maxpool_layer1.sv
// 2x2 stride-2 signed max pooling over a square layer-0 image held in memory.
// Reads each window as four pixels (TL, TR, BL, BR), then writes the maximum to layer-1 memory.
module maxpool_layer1 #(
    parameter int DATA_BITS = 20,
    parameter int IMG_W     = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [11:0]                 rd_addr,
    input  logic signed [DATA_BITS-1:0] rd_data,
    output logic                        wr_en,
    output logic [9:0]                  wr_addr,
    output logic signed [DATA_BITS-1:0] wr_data
);

    localparam int OUT_W = IMG_W / 2;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

    state_t                      state, state_nx;
    logic [1:0]                  k;
    logic [CW-1:0]               orow, ocol;
    logic signed [DATA_BITS-1:0] max_val;
    logic [CW:0]                 row_px, col_px;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RD;
            RD:      if (k == 2'd3) state_nx = WAIT;
            WAIT:    state_nx = WR;
            WR:      state_nx = (orow == LAST && ocol == LAST) ? DONE : RD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Read data lags the address by one cycle: the k=0 datum lands in RD k=1,
    // and the k=3 datum lands in WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k       <= '0;
            orow    <= '0;
            ocol    <= '0;
            max_val <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k    <= '0;
                        orow <= '0;
                        ocol <= '0;
                    end
                end
                RD: begin
                    k <= k + 2'd1;
                    if (k == 2'd1)
                        max_val <= rd_data;
                    else if (k != 2'd0 && rd_data > max_val)
                        max_val <= rd_data;
                end
                WAIT: begin
                    if (rd_data > max_val) max_val <= rd_data;
                end
                WR: begin
                    if (ocol == LAST) begin
                        ocol <= '0;
                        orow <= orow + 1'b1;
                    end else begin
                        ocol <= ocol + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign row_px = {orow, k[1]};
    assign col_px = {ocol, k[0]};

    always_comb begin
        busy    = (state == RD) || (state == WAIT) || (state == WR);
        done    = (state == DONE);
        wr_en   = (state == WR);
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        if (state == RD)
            rd_addr = 12'(row_px) * 12'(IMG_W) + 12'(col_px);
        if (state == WR) begin
            wr_addr = 10'(orow) * 10'(OUT_W) + 10'(ocol);
            wr_data = max_val;
        end
    end

endmodule

// File: tb/tb_maxpool_layer1.sv
// Directed + randomized bench for maxpool_layer1 with a behavioural memory and pooling model.
module tb_maxpool_layer1;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic               busy, done, wr_en;
    logic [11:0]        rd_addr;
    logic signed [19:0] rd_data;
    logic [9:0]         wr_addr;
    logic signed [19:0] wr_data;

    logic signed [19:0] mem [4096];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_cnt, done_cnt, first_busy, done_cyc;
    int          wa[$];
    logic [19:0] wd[$];
    int          rd_trace[$];

    maxpool_layer1 #(.DATA_BITS(20), .IMG_W(64)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rd_data <= mem[rd_addr];

    always @(negedge clock) begin
        cyc++;
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(wr_data);
        end
        if (busy) begin
            busy_cnt++;
            rd_trace.push_back(int'(rd_addr));
            if (first_busy < 0) first_busy = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        wa.delete();
        wd.delete();
        rd_trace.delete();
        busy_cnt   = 0;
        done_cnt   = 0;
        first_busy = -1;
        done_cyc   = -1;
    endtask

    function automatic logic [19:0] model_max(input int w);
        int r = w / 32;
        int c = w % 32;
        logic signed [19:0] m = mem[(2 * r) * 64 + 2 * c];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (mem[(2 * r + dr) * 64 + 2 * c + dc] > m)
                    m = mem[(2 * r + dr) * 64 + 2 * c + dc];
        return m;
    endfunction

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic run_pass(input int repulse_at, output bit got);
        clear_stats();
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 7000 && !got; i++) begin
            @(negedge clock);
            if (repulse_at > 0 && i == repulse_at) begin
                #1 start = 1'b1;
                @(posedge clock); #1 start = 1'b0;
            end
            if (done_cnt > 0) got = 1'b1;
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic check_pass(input string tag, input bit got);
        int bad = 0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_write_count"}, 64'(wa.size()), 64'd1024);
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || wd[i] !== model_max(i)) bad++;
        check({tag, "_write_mismatches"}, 64'(bad), 64'd0);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd6144);
        check({tag, "_done_latency"}, 64'(done_cyc - first_busy), 64'd6144);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        bit got;
        reset = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 20'(a);
        clear_stats();
        repeat (3) @(negedge clock);
        check("reset_outputs", 64'({busy, done, wr_en, wr_addr, wr_data, rd_addr}), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_busy", 64'(busy), 64'd0);

        // Address-valued image.
        run_pass(0, got);
        check_pass("ramp", got);
        check("ramp_first_data", 64'(wd.size() > 0 ? wd[0] : 20'hx), 64'd65);
        check("ramp_last_data", 64'(wd.size() > 1023 ? wd[1023] : 20'hx), 64'd4095);
        if (rd_trace.size() >= 210) begin
            check("trace_tl", 64'(rd_trace[204]), 64'd132);
            check("trace_tr", 64'(rd_trace[205]), 64'd133);
            check("trace_bl", 64'(rd_trace[206]), 64'd196);
            check("trace_br", 64'(rd_trace[207]), 64'd197);
            check("trace_wait_zero", 64'(rd_trace[208]), 64'd0);
            check("trace_wr_zero", 64'(rd_trace[209]), 64'd0);
        end else begin
            check("trace_length", 64'(rd_trace.size()), 64'd6144);
        end

        // Random signed image with directed tie / negative windows and a stray start.
        for (int a = 0; a < 4096; a++) mem[a] = 20'($urandom);
        mem[0] = 20'd5;      mem[1] = 20'd9;      mem[64] = 20'd9;      mem[65] = 20'd2;
        mem[2] = 20'hFFFFF;  mem[3] = 20'hFFFFE;  mem[66] = 20'h80000;  mem[67] = 20'hFFFF0;
        run_pass(100, got);
        check_pass("rand", got);
        check("tie_window", 64'(wd.size() > 0 ? wd[0] : 20'hx), 64'd9);
        check("neg_window", 64'(wd.size() > 1 ? wd[1] : 20'hx), 64'hFFFFF);

        // Reset in the middle of a pass.
        for (int a = 0; a < 4096; a++) mem[a] = 20'(a);
        clear_stats();
        pulse_start();
        for (int i = 0; i < 4000 && wa.size() < 500; i++) @(negedge clock);
        check("reached_500", 64'(wa.size()), 64'd500);
        #1 reset = 1'b1;
        #1 check("midreset_outputs", 64'({busy, done, wr_en, wr_addr, wr_data, rd_addr}), 64'd0);
        check("midreset_wr_en", 64'(wr_en), 64'd0);
        repeat (3) @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;
        repeat (6) @(negedge clock);
        check("post_reset_no_writes", 64'(wa.size()), 64'd500);
        check("post_reset_idle", 64'({busy, done}), 64'd0);

        // All-zero image after the abandoned pass.
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        run_pass(0, got);
        check_pass("zero", got);
        check("zero_restart_addr", 64'(wa.size() > 0 ? wa[0] : -1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
